// File: rtl/shift_engine.sv
// Serial shift engine: one word out and one word in per transfer, with the
// sample and shift timing paced by edge pulses from the peripheral clock.
module shift_engine #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             sample_edge,
  input  logic             shift_edge,
  input  logic             serial_in,
  output logic             serial_out,
  input  logic             abort,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             sout_q;
  logic [WIDTH-1:0] rx_q;
  logic             rv_q;

  logic [WIDTH-1:0] smp_d;
  logic [WIDTH-1:0] sr_d;
  logic             load_bit;
  logic             out_bit_d;
  logic             last_smp;

  // New bit enters at the far end from the output end.
  assign smp_d = MSB_FIRST ? {sr_q[WIDTH-2:0], serial_in}
                           : {serial_in, sr_q[WIDTH-1:1]};

  // A shift coinciding with a sample sees the post-sample register.
  assign sr_d      = sample_edge ? smp_d : sr_q;
  assign out_bit_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
  assign load_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign last_smp  = sample_edge && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      rx_q    <= '0;
      rv_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            sr_q    <= load_data;
            sout_q  <= load_bit;
            cnt_q   <= '0;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (abort) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            if (sample_edge) begin
              sr_q <= smp_d;
              if (last_smp) begin
                rx_q    <= smp_d;
                rv_q    <= 1'b1;
                cnt_q   <= '0;
                state_q <= IDLE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            if (shift_edge) begin
              sout_q <= out_bit_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == ACTIVE);
  assign serial_out = sout_q;
  assign rx_data    = rx_q;
  assign rx_valid   = rv_q;

endmodule

// File: tb/tb_shift_engine.sv
// Bench for shift_engine: MSB-first and LSB-first instances share stimulus
// and are compared against a bitstream-level reference model.
module tb_shift_engine;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         sample_edge;
  logic         shift_edge;
  logic         serial_in;
  logic         abort;

  logic         rdy0, busy0, so0, rv0;
  logic [W-1:0] rx0;
  logic         rdy1, busy1, so1, rv1;
  logic [W-1:0] rx1;

  shift_engine #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy0),
    .sample_edge(sample_edge), .shift_edge(shift_edge),
    .serial_in(serial_in), .serial_out(so0),
    .abort(abort),
    .rx_data(rx0), .rx_valid(rv0), .busy(busy0)
  );

  shift_engine #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy1),
    .sample_edge(sample_edge), .shift_edge(shift_edge),
    .serial_in(serial_in), .serial_out(so1),
    .abort(abort),
    .rx_data(rx1), .rx_valid(rv1), .busy(busy1)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model index 0 = MSB-first instance, 1 = LSB-first instance.
  bit         m_act [2];
  bit [W-1:0] m_tx  [2];
  int         m_k   [2];
  bit         m_rxb [2][W];
  bit         m_sout[2];
  bit [W-1:0] m_rx  [2];
  bit         m_rv  [2];

  // Line bitstream: transmitted bits in wire order, then received bits.
  function automatic bit stream_bit(int d, int j);
    if (j < W) return (d == 0) ? m_tx[d][W-1-j] : m_tx[d][j];
    return m_rxb[d][j-W];
  endfunction

  function automatic bit [W-1:0] assemble(int d);
    bit [W-1:0] w = '0;
    for (int j = 0; j < W; j++) begin
      if (d == 0) w[W-1-j] = m_rxb[d][j];
      else        w[j]     = m_rxb[d][j];
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_tx[d] = '0; m_k[d] = 0;
      m_sout[d] = 0; m_rx[d] = '0; m_rv[d] = 0;
    end
  endtask

  task automatic model_clock();
    for (int d = 0; d < 2; d++) begin
      m_rv[d] = 0;
      if (!reset_n) begin
        m_act[d] = 0; m_tx[d] = '0; m_k[d] = 0;
        m_sout[d] = 0; m_rx[d] = '0;
      end else if (!m_act[d]) begin
        if (load_valid) begin
          m_act[d] = 1; m_tx[d] = load_data; m_k[d] = 0;
          m_sout[d] = stream_bit(d, 0);
        end
      end else if (abort) begin
        m_act[d] = 0; m_k[d] = 0;
      end else begin
        if (sample_edge) begin
          m_rxb[d][m_k[d]] = serial_in;
          m_k[d]++;
        end
        if (shift_edge) m_sout[d] = stream_bit(d, m_k[d]);
        if (sample_edge && m_k[d] == W) begin
          m_rx[d] = assemble(d);
          m_rv[d] = 1; m_act[d] = 0; m_k[d] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_model();
    chk("msb.serial_out", 32'(so0),   32'(m_sout[0]));
    chk("msb.busy",       32'(busy0), 32'(m_act[0]));
    chk("msb.load_ready", 32'(rdy0),  32'(!m_act[0]));
    chk("msb.rx_valid",   32'(rv0),   32'(m_rv[0]));
    chk("msb.rx_data",    32'(rx0),   32'(m_rx[0]));
    chk("lsb.serial_out", 32'(so1),   32'(m_sout[1]));
    chk("lsb.busy",       32'(busy1), 32'(m_act[1]));
    chk("lsb.load_ready", 32'(rdy1),  32'(!m_act[1]));
    chk("lsb.rx_valid",   32'(rv1),   32'(m_rv[1]));
    chk("lsb.rx_data",    32'(rx1),   32'(m_rx[1]));
  endtask

  task automatic drive(input bit lv, input bit [W-1:0] ld, input bit se,
                       input bit sh, input bit si, input bit ab);
    load_valid = lv; load_data = ld; sample_edge = se;
    shift_edge = sh; serial_in = si; abort = ab;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"},  32'({busy0, busy1}), 32'(0));
    chk({tag, ".ready"}, 32'({rdy0, rdy1}),   32'(3));
    chk({tag, ".sout"},  32'({so0, so1}),     32'(0));
    chk({tag, ".rv"},    32'({rv0, rv1}),     32'(0));
    chk({tag, ".rx"},    32'({rx0, rx1}),     32'(0));
  endtask

  typedef struct {
    bit         lv;
    bit [W-1:0] ld;
    bit         se;
    bit         sh;
    bit         si;
    bit         ab;
    bit         e_sout;
    bit         e_busy;
    bit         e_rv;
    bit [W-1:0] e_rx;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit [W-1:0] sin_pat;
    bit [W-1:0] so_pat;
    logic [W-1:0] word;

    // Palindromic patterns: same line sequence for both bit orders.
    sin_pat = 8'h3C;
    so_pat  = 8'hA5;
    tbl.push_back('{1, 8'hA5, 0, 0, 0, 0, 1, 1, 0, 8'h00});
    for (int i = 0; i < W; i++) begin
      tbl.push_back('{0, 8'h00, 1, 0, sin_pat[W-1-i], 0,
                      so_pat[W-1-i], (i < W-1), (i == W-1),
                      (i == W-1) ? 8'h3C : 8'h00});
      if (i < W-1)
        tbl.push_back('{0, 8'h00, 0, 1, 0, 0,
                        so_pat[W-2-i], 1, 0, 8'h00});
    end
    tbl.push_back('{0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h3C});
    tbl.push_back('{0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'h3C});
    tbl.push_back('{0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 8'h3C});

    reset_n = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("reset_async");
    step();
    step();
    reset_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].lv, tbl[i].ld, tbl[i].se, tbl[i].sh,
            tbl[i].si, tbl[i].ab);
      step();
      chk("tbl.msb.sout", 32'(so0),   32'(tbl[i].e_sout));
      chk("tbl.lsb.sout", 32'(so1),   32'(tbl[i].e_sout));
      chk("tbl.msb.busy", 32'(busy0), 32'(tbl[i].e_busy));
      chk("tbl.lsb.busy", 32'(busy1), 32'(tbl[i].e_busy));
      chk("tbl.msb.rv",   32'(rv0),   32'(tbl[i].e_rv));
      chk("tbl.lsb.rv",   32'(rv1),   32'(tbl[i].e_rv));
      chk("tbl.msb.rx",   32'(rx0),   32'(tbl[i].e_rx));
      chk("tbl.lsb.rx",   32'(rx1),   32'(tbl[i].e_rx));
    end

    // Abort coincident with the fourth sample.
    drive(1, 8'hFF, 0, 0, 0, 0); step();
    repeat (3) begin drive(0, 8'h00, 1, 0, 1, 0); step(); end
    drive(0, 8'h00, 1, 1, 1, 1); step();
    chk("abort.busy", 32'(busy0), 32'(0));
    chk("abort.rv",   32'(rv0),   32'(0));
    chk("abort.rx",   32'(rx0),   32'(8'h3C));
    drive(0, 8'h00, 0, 0, 0, 0); step();

    // Load held high with another word during a transfer.
    drive(1, 8'h0F, 0, 0, 0, 0); step();
    word = {7'b0, so0};
    for (int i = 0; i < W; i++) begin
      drive(1, 8'hF0, 1, 0, 1'($urandom), 0); step();
      if (i < W-1) begin
        drive(1, 8'hF0, 0, 1, 0, 0); step();
        word = {word[W-2:0], so0};
      end
    end
    chk("ignore_load.tx", 32'(word), 32'(8'h0F));
    chk("ignore_load.rv", 32'(rv0),  32'(1));
    drive(1, 8'hF0, 0, 0, 0, 0); step();
    chk("b2b.busy", 32'(busy0), 32'(1));
    chk("b2b.sout", 32'(so0),   32'(1));
    drive(0, 8'h00, 0, 0, 0, 1); step();

    // Coincident sample and shift every cycle.
    drive(1, 8'h80, 0, 0, 0, 0); step();
    for (int i = 0; i < W; i++) begin
      drive(0, 8'h00, 1, 1, 1, 0); step();
      chk("coinc.sout", 32'(so0), 32'(i == W-1));
    end
    chk("coinc.rx_msb", 32'(rx0), 32'(8'hFF));
    chk("coinc.rx_lsb", 32'(rx1), 32'(8'hFF));
    drive(0, 8'h00, 0, 0, 0, 0); step();

    // Asynchronous reset part way through a transfer.
    drive(1, 8'h55, 0, 0, 0, 0); step();
    repeat (5) begin drive(0, 8'h00, 1, 1, 1'($urandom), 0); step(); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("reset_mid");
    drive(0, 8'h00, 0, 0, 0, 0); step();
    reset_n = 1'b1;
    drive(1, 8'h55, 0, 0, 0, 0); step();
    for (int i = 0; i < W; i++) begin
      word = 8'hC3;
      drive(0, 8'h00, 1, 1, word[W-1-i], 0); step();
    end
    chk("post_reset.rx_msb", 32'(rx0), 32'(8'hC3));
    chk("post_reset.rx_lsb", 32'(rx1), 32'(8'hC3));
    chk("post_reset.rv",     32'(rv0), 32'(1));

    repeat (3000) begin
      drive($urandom_range(0, 9) < 3, 8'($urandom),
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
            1'($urandom), $urandom_range(0, 99) < 3);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
